dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller that sequences an array of `cache_line` storage entries between a single CPU requester and a word-wide memory port. It sits between the MEM stage of the brisc pipeline and the memory model. It performs tag lookup, hit response, miss refill and write-through forwarding, and owns the resettable valid bits for every line.

## Interface
- `NUM_LINES`, 4: number of lines; power of two, at least 2.
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, `XLEN`: word width; one word per line.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `flush` in 1: invalidate all lines.
- `cpu_req_valid` in 1: CPU request present.
- `cpu_req_ready` out 1: controller accepts a request.
- `cpu_req_write` in 1: 1 means store, 0 means load.
- `cpu_req_addr` in `ADDR_WIDTH`: byte address; bits [1:0] are ignored.
- `cpu_req_wdata` in `DATA_WIDTH`: store data.
- `cpu_resp_valid` out 1: one-cycle completion pulse. There is no back-pressure; the CPU must take it.
- `cpu_resp_rdata` out `DATA_WIDTH`: load data, valid when `cpu_resp_valid` is high on a load.
- `mem_req_valid` out 1: memory request present.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_write` out 1: memory store.
- `mem_req_addr` out `ADDR_WIDTH`: word-aligned address, bits [1:0] = 0.
- `mem_req_wdata` out `DATA_WIDTH`: store data.
- `mem_resp_valid` in 1: read data returned (loads only).
- `mem_resp_rdata` in `DATA_WIDTH`: refill data.

## Operation
- Address split:
  - `IDX_W = $clog2(NUM_LINES)`.
  - index = `addr[IDX_W+1:2]`.
  - tag = `addr[ADDR_WIDTH-1:IDX_W+2]`, so `TAG_WIDTH = ADDR_WIDTH-IDX_W-2`.
- On handshake (`cpu_req_valid & cpu_req_ready`), the request fields are registered and used for the whole transaction.
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT.
- IDLE:
  - `cpu_req_ready = !flush`.
  - If `flush` is high, all valid bits clear at the next edge and no request is accepted.
  - Otherwise a handshake moves to LOOKUP.
- LOOKUP: hit = `valid[idx] & (tag_out[idx] == tag)`.
  - Load hit: `cpu_resp_valid=1`, `cpu_resp_rdata = data_out[idx]`, then go to IDLE.
  - Load miss or any store: go to MEM_REQ.
- MEM_REQ:
  - `mem_req_valid=1`; address, write and wdata are held stable until `mem_req_ready`.
  - Store, on handshake: `cpu_resp_valid=1` that cycle, then go to IDLE. If the store hit in LOOKUP, the line is written with the new data (valid=1, same tag) on that same edge. A store miss leaves the cache unchanged.
  - Load, on handshake: go to MEM_WAIT.
- MEM_WAIT, on `mem_resp_valid`:
  - Line[idx] is written (valid=1, registered tag, `mem_resp_rdata`).
  - `cpu_resp_valid=1` with `cpu_resp_rdata = mem_resp_rdata` in the same cycle.
  - Then go to IDLE.
- `mem_resp_valid` outside MEM_WAIT is ignored.
- `flush` outside IDLE is ignored; the requester holds it until it is taken.
- A refill overwrites the indexed line unconditionally. No dirty state exists, because the cache is write-through.

## Timing
- Reset values:
  - state = IDLE.
  - all valid bits = 0.
  - `cpu_req_ready=1` (when `flush=0`).
  - `cpu_resp_valid=0`, `mem_req_valid=0`, `mem_req_write=0`.
  - `mem_req_addr=0`, `mem_req_wdata=0`, `cpu_resp_rdata=0`.
- Line tag and data are not reset.
- Load hit: response in the cycle after acceptance (latency 1). The next accept is one cycle later, so throughput is one request per 2 cycles.
- Load miss: 1 (LOOKUP) + memory-handshake wait + at least 1 cycle in MEM_WAIT. The response shares the cycle with `mem_resp_valid`.
- Store: response in the `mem_req` handshake cycle. The earliest is 2 cycles after acceptance.
- Outputs are driven from registered state; `cpu_resp_rdata` on a miss is combinationally forwarded from `mem_resp_rdata`.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronous). The in-flight request is dropped with no response, and partially filled lines are invalid.
- `mem_req_ready` and `mem_resp_valid` in the same MEM_REQ cycle: the response is ignored, and memory must return data no earlier than the following cycle.

## Structure
- `brisc_pkg` gets the `dcache_state_e` enum (IDLE, LOOKUP, MEM_REQ, MEM_WAIT).
- `IDX_W` and `TAG_WIDTH` are local parameters derived in the module.
- Storage is a generate array of `NUM_LINES` `cache_line` instances (`TAG_WIDTH`, `DATA_WIDTH`).
  - Instance `valid_in` is tied to 1; the controller-owned `valid` register vector (async active-low reset) is authoritative.
  - Per-line `write` = decoded index AND (refill-complete OR store-hit-handshake).
- Request registers use `ff`. The FSM is a single always_ff plus a combinational next-state/output block.

## Test plan
- Reset, then a load at 0x0000_0010, with memory accepting immediately and returning 0xDEAD_BEEF one cycle later: the response carries 0xDEAD_BEEF on the `mem_resp_valid` cycle. Reloading the same address then hits, with the response 1 cycle after accept and no `mem_req_valid`.
- Load 0x10, then a store of 0x1234_5678 to 0x10 with `mem_req_ready` delayed 3 cycles: `mem_req_valid` is held stable for 4 cycles and the response comes on the handshake. The next load of 0x10 hits with 0x1234_5678.
- Store to an uncached address 0x20, then load 0x20: the store goes to memory without allocating, and the load misses with a refill.
- With `NUM_LINES=4`, load 0x10, then load 0x50 (same index 0, different tag), then reload 0x10: the third access misses (eviction).
- `flush` with `cpu_req_valid` both high in IDLE: `cpu_req_ready=0` and all valids clear. A previously cached address then misses.
- Reset asserted while in MEM_WAIT: `mem_req_valid` and `cpu_resp_valid` are 0 immediately, no response is issued, and a later `mem_resp_valid` is ignored. A subsequent load to the same line misses.

Source files
------------

// File: rtl/brisc_pkg.sv
// -----------------------------------------------------------------------------
// brisc_pkg
// Shared types and constants for the brisc pipeline blocks.
//   XLEN            : machine word width in bits
//   dcache_state_e  : data-cache controller sequencing states
// -----------------------------------------------------------------------------
package brisc_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_REQ  = 2'd2,
        MEM_WAIT = 2'd3
    } dcache_state_e;

endpackage

// File: rtl/cache_line.sv
// -----------------------------------------------------------------------------
// cache_line
// One storage entry of the data cache: valid flag, tag and one data word.
// Contents are not reset; the owning controller keeps the authoritative
// resettable valid bit.
//   i_clk      : clock, rising edge
//   i_write    : load i_valid_in / i_tag_in / i_data_in on this edge
//   i_valid_in : valid flag to store
//   i_tag_in   : tag to store
//   i_data_in  : data word to store
//   o_valid    : stored valid flag
//   o_tag      : stored tag
//   o_data     : stored data word
// -----------------------------------------------------------------------------
module cache_line #(
    parameter int TAG_WIDTH  = 28,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_write,
    input  logic                  i_valid_in,
    input  logic [TAG_WIDTH-1:0]  i_tag_in,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    output logic                  o_valid,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_write) begin
            r_valid <= i_valid_in;
            r_tag   <= i_tag_in;
            r_data  <= i_data_in;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_data  = r_data;

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache controller with
// one word per line. Sits between the CPU MEM stage and a word-wide memory.
//   i_clk / i_rst_n      : clock, asynchronous active-low reset
//   i_flush              : invalidate all lines (taken only in IDLE)
//   i_cpu_req_*          : CPU request (valid/write/addr/wdata), o_cpu_req_ready
//   o_cpu_resp_valid     : one-cycle completion pulse, o_cpu_resp_rdata on loads
//   o_mem_req_*          : memory request (valid/write/addr/wdata), i_mem_req_ready
//   i_mem_resp_valid     : refill data present on i_mem_resp_rdata
// -----------------------------------------------------------------------------
module dcache_ctrl
    import brisc_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_cpu_req_valid,
    output logic                  o_cpu_req_ready,
    input  logic                  i_cpu_req_write,
    input  logic [ADDR_WIDTH-1:0] i_cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_req_wdata,
    output logic                  o_cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] o_cpu_resp_rdata,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_write,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
    input  logic                  i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_resp_rdata
);

    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int TAG_WIDTH = ADDR_WIDTH - IDX_W - 2;

    dcache_state_e r_state;
    dcache_state_e w_state_next;

    // Request captured at acceptance; only the word address is kept.
    logic                  r_write;
    logic [ADDR_WIDTH-3:0] r_word_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_hit;      // LOOKUP result, needed when a store completes
    logic [NUM_LINES-1:0]  r_valid;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_flush_take;
    logic                  w_refill;
    logic                  w_store_hit_hs;
    logic [DATA_WIDTH-1:0] w_line_wdata;
    logic [NUM_LINES-1:0]  w_line_we;
    logic [NUM_LINES-1:0]  w_line_valid;
    logic [TAG_WIDTH-1:0]  w_line_tag  [NUM_LINES];
    logic [DATA_WIDTH-1:0] w_line_data [NUM_LINES];
    logic                  w_unused_addr_lsbs;

    // Byte offset within the word has no meaning for a word-wide cache.
    assign w_unused_addr_lsbs = ^i_cpu_req_addr[1:0];

    assign w_idx = r_word_addr[IDX_W-1:0];
    assign w_tag = r_word_addr[ADDR_WIDTH-3:IDX_W];

    // The line's own valid flag only ever goes high alongside r_valid, so the
    // AND never changes the answer once a line has been written.
    assign w_hit = r_valid[w_idx] & w_line_valid[w_idx] & (w_line_tag[w_idx] == w_tag);

    assign w_line_wdata = w_refill ? i_mem_resp_rdata : r_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            assign w_line_we[gi] = (w_idx == IDX_W'(gi)) & (w_refill | w_store_hit_hs);

            cache_line #(
                .TAG_WIDTH  (TAG_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_line (
                .i_clk      (i_clk),
                .i_write    (w_line_we[gi]),
                .i_valid_in (1'b1),
                .i_tag_in   (w_tag),
                .i_data_in  (w_line_wdata),
                .o_valid    (w_line_valid[gi]),
                .o_tag      (w_line_tag[gi]),
                .o_data     (w_line_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write     <= 1'b0;
            r_word_addr <= '0;
            r_wdata     <= '0;
            r_hit       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write     <= i_cpu_req_write;
                r_word_addr <= i_cpu_req_addr[ADDR_WIDTH-1:2];
                r_wdata     <= i_cpu_req_wdata;
            end
            if (r_state == LOOKUP) begin
                r_hit <= w_hit;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (w_flush_take) begin
            r_valid <= '0;
        end else begin
            r_valid <= r_valid | w_line_we;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        o_cpu_req_ready  = 1'b0;
        o_cpu_resp_valid = 1'b0;
        o_cpu_resp_rdata = '0;
        o_mem_req_valid  = 1'b0;
        w_accept         = 1'b0;
        w_flush_take     = 1'b0;
        w_refill         = 1'b0;
        w_store_hit_hs   = 1'b0;
        case (r_state)
            IDLE: begin
                o_cpu_req_ready = !i_flush;
                if (i_flush) begin
                    w_flush_take = 1'b1;
                end else if (i_cpu_req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!r_write && w_hit) begin
                    o_cpu_resp_valid = 1'b1;
                    o_cpu_resp_rdata = w_line_data[w_idx];
                    w_state_next     = IDLE;
                end else begin
                    w_state_next = MEM_REQ;
                end
            end
            MEM_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    if (r_write) begin
                        o_cpu_resp_valid = 1'b1;
                        w_store_hit_hs   = r_hit;
                        w_state_next     = IDLE;
                    end else begin
                        w_state_next = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (i_mem_resp_valid) begin
                    w_refill         = 1'b1;
                    o_cpu_resp_valid = 1'b1;
                    o_cpu_resp_rdata = i_mem_resp_rdata;
                    w_state_next     = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_mem_req_write = r_write;
    assign o_mem_req_addr  = {r_word_addr, 2'b00};
    assign o_mem_req_wdata = r_wdata;

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
// Self-checking bench for dcache_ctrl (NUM_LINES=4). A line-level cache model
// and a word-addressed memory model predict hit/miss, response timing and data.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_cpu_req_valid;
    logic        o_cpu_req_ready;
    logic        i_cpu_req_write;
    logic [31:0] i_cpu_req_addr;
    logic [31:0] i_cpu_req_wdata;
    logic        o_cpu_resp_valid;
    logic [31:0] o_cpu_resp_rdata;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic        o_mem_req_write;
    logic [31:0] o_mem_req_addr;
    logic [31:0] o_mem_req_wdata;
    logic        i_mem_resp_valid;
    logic [31:0] i_mem_resp_rdata;

    dcache_ctrl u_dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_flush          (i_flush),
        .i_cpu_req_valid  (i_cpu_req_valid),
        .o_cpu_req_ready  (o_cpu_req_ready),
        .i_cpu_req_write  (i_cpu_req_write),
        .i_cpu_req_addr   (i_cpu_req_addr),
        .i_cpu_req_wdata  (i_cpu_req_wdata),
        .o_cpu_resp_valid (o_cpu_resp_valid),
        .o_cpu_resp_rdata (o_cpu_resp_rdata),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_req_write  (o_mem_req_write),
        .o_mem_req_addr   (o_mem_req_addr),
        .o_mem_req_wdata  (o_mem_req_wdata),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_rdata (i_mem_resp_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: which word each of the 4 lines holds, and memory.
    bit          m_valid [4];
    logic [29:0] m_word  [4];
    logic [31:0] m_data  [4];
    logic [31:0] mem_model [logic [29:0]];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        int          rdy;
        int          rsp;
        bit          junk;
        bit          exp_mem;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endtask

    // Starts on a falling edge, returns on a falling edge with the DUT idle.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int rdy_dly, input int rsp_dly, input bit junk,
                          output bit saw_mem, output logic [31:0] rdata);
        logic [29:0] wa;
        int          idx;
        bit          hit, exp_mem, in_wait, done, hs, resp_now;
        logic [31:0] mem_val;
        int          req_cyc, wait_cyc;
        wa      = addr[31:2];
        idx     = int'(addr[3:2]);
        hit     = m_valid[idx] && (m_word[idx] == wa);
        exp_mem = wr || !hit;
        if (!mem_model.exists(wa)) mem_model[wa] = $urandom;
        mem_val  = mem_model[wa];
        saw_mem  = 1'b0;
        rdata    = '0;
        in_wait  = 1'b0;
        done     = 1'b0;
        req_cyc  = 0;
        wait_cyc = 0;

        i_cpu_req_valid = 1'b1;
        i_cpu_req_write = wr;
        i_cpu_req_addr  = addr;
        i_cpu_req_wdata = wd;
        #1 chk("req_ready", o_cpu_req_ready, 1);
        @(negedge i_clk);
        // Request must have been captured: scramble the live bus.
        i_cpu_req_valid = 1'b0;
        i_cpu_req_write = 1'($urandom);
        i_cpu_req_addr  = $urandom;
        i_cpu_req_wdata = $urandom;

        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            i_mem_req_ready = o_mem_req_valid && (req_cyc == rdy_dly);
            if (in_wait && wait_cyc == rsp_dly) begin
                i_mem_resp_valid = 1'b1;
                i_mem_resp_rdata = mem_val;
            end else begin
                i_mem_resp_valid = junk && !in_wait;
                i_mem_resp_rdata = $urandom;
            end
            #1;
            hs       = o_mem_req_valid && i_mem_req_ready;
            resp_now = (!exp_mem && cyc == 1) || (wr && hs) ||
                       (!wr && exp_mem && in_wait && wait_cyc == rsp_dly);
            chk("resp_valid", o_cpu_resp_valid, resp_now);
            if (o_mem_req_valid) begin
                saw_mem = 1'b1;
                chk("mem_addr", o_mem_req_addr, {addr[31:2], 2'b00});
                chk("mem_write", o_mem_req_write, wr);
                if (wr) chk("mem_wdata", o_mem_req_wdata, wd);
            end
            if (resp_now && !wr) begin
                chk("resp_rdata", o_cpu_resp_rdata, hit ? m_data[idx] : mem_val);
                rdata = o_cpu_resp_rdata;
            end
            if (resp_now) done = 1'b1;
            if (in_wait) wait_cyc++;
            if (hs && !wr) in_wait = 1'b1;
            if (o_mem_req_valid && !hs) req_cyc++;
            @(negedge i_clk);
        end
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout addr=%h wr=%0d actual=no_response required=response", addr, wr);
        end
        chk("mem_used", saw_mem, exp_mem);
        $display("txn %s addr=%h wd=%h hit=%0d rdata=%h", wr ? "ST" : "LD", addr, wd, hit, rdata);

        if (wr) begin
            mem_model[wa] = wd;
            if (hit) m_data[idx] = wd;
        end else if (!hit) begin
            m_valid[idx] = 1'b1;
            m_word[idx]  = wa;
            m_data[idx]  = mem_val;
        end
    endtask

    task automatic do_flush(input bit with_req);
        i_flush         = 1'b1;
        i_cpu_req_valid = with_req;
        i_cpu_req_write = 1'b0;
        i_cpu_req_addr  = 32'h10;
        #1 chk("flush_ready", o_cpu_req_ready, 0);
        @(negedge i_clk);
        i_flush         = 1'b0;
        i_cpu_req_valid = 1'b0;
        // Still idle (ready only in IDLE): the request was not taken.
        #1 chk("flush_not_taken", o_cpu_req_ready, 1);
        chk("flush_no_resp", o_cpu_resp_valid, 0);
        model_clear();
        $display("txn FLUSH req=%0d", with_req);
        @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          saw;
        logic [31:0] rd;
        logic [27:0] tag_pool [3];

        tbl[0] = '{0, 32'h10, 32'h0,        0, 0, 0, 1, 32'hDEAD_BEEF};
        tbl[1] = '{0, 32'h10, 32'h0,        0, 0, 1, 0, 32'hDEAD_BEEF};
        tbl[2] = '{1, 32'h10, 32'h1234_5678, 3, 0, 0, 1, 32'h0};
        tbl[3] = '{0, 32'h10, 32'h0,        0, 0, 1, 0, 32'h1234_5678};
        tbl[4] = '{1, 32'h20, 32'hCAFE_F00D, 1, 0, 1, 1, 32'h0};
        tbl[5] = '{0, 32'h20, 32'h0,        2, 2, 1, 1, 32'hCAFE_F00D};
        tbl[6] = '{0, 32'h50, 32'h0,        0, 1, 0, 1, 32'h5050_5050};
        tbl[7] = '{0, 32'h10, 32'h0,        0, 0, 0, 1, 32'h1234_5678};
        tbl[8] = '{0, 32'h13, 32'h0,        0, 0, 1, 0, 32'h1234_5678};
        tbl[9] = '{0, 32'h14, 32'h0,        1, 0, 1, 1, 32'h1414_1414};

        mem_model[30'h04] = 32'hDEAD_BEEF;
        mem_model[30'h08] = 32'h2020_2020;
        mem_model[30'h14] = 32'h5050_5050;
        mem_model[30'h05] = 32'h1414_1414;
        model_clear();

        i_rst_n          = 1'b0;
        i_flush          = 1'b0;
        i_cpu_req_valid  = 1'b0;
        i_cpu_req_write  = 1'b0;
        i_cpu_req_addr   = '0;
        i_cpu_req_wdata  = '0;
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_resp_rdata = '0;
        repeat (2) @(negedge i_clk);
        chk("rst_req_ready", o_cpu_req_ready, 1);
        chk("rst_resp_valid", o_cpu_resp_valid, 0);
        chk("rst_mem_valid", o_mem_req_valid, 0);
        chk("rst_mem_write", o_mem_req_write, 0);
        chk("rst_mem_addr", o_mem_req_addr, 0);
        chk("rst_mem_wdata", o_mem_req_wdata, 0);
        chk("rst_resp_rdata", o_cpu_resp_rdata, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 10; i++) begin
            access(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rdy, tbl[i].rsp, tbl[i].junk, saw, rd);
            chk("tbl_mem_used", saw, tbl[i].exp_mem);
            if (!tbl[i].wr) chk("tbl_rdata", rd, tbl[i].exp_rdata);
        end

        // Flush with a competing request: everything cached must miss after.
        do_flush(1'b1);
        access(0, 32'h10, 32'h0, 0, 0, 0, saw, rd);
        chk("flush_then_miss", saw, 1);
        chk("flush_then_data", rd, 32'h1234_5678);

        // Reset while waiting for refill data.
        i_cpu_req_valid = 1'b1;
        i_cpu_req_write = 1'b0;
        i_cpu_req_addr  = 32'h24;
        @(negedge i_clk);
        i_cpu_req_valid = 1'b0;
        @(negedge i_clk);
        #1 chk("rstseq_mem_req", o_mem_req_valid, 1);
        i_mem_req_ready = 1'b1;
        @(negedge i_clk);
        i_mem_req_ready = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 chk("rstseq_mem_valid", o_mem_req_valid, 0);
        chk("rstseq_resp_valid", o_cpu_resp_valid, 0);
        chk("rstseq_mem_addr", o_mem_req_addr, 0);
        @(negedge i_clk);
        i_mem_resp_valid = 1'b1;
        i_mem_resp_rdata = 32'h7777_0000;
        #1 chk("rstseq_resp_in_rst", o_cpu_resp_valid, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 chk("rstseq_late_resp", o_cpu_resp_valid, 0);
        @(negedge i_clk);
        i_mem_resp_valid = 1'b0;
        model_clear();
        $display("txn RESET mid-refill addr=00000024");
        access(0, 32'h24, 32'h0, 0, 0, 0, saw, rd);
        chk("rstseq_then_miss", saw, 1);

        // Randomized traffic over a small address pool to force hits and evictions.
        tag_pool[0] = 28'h0000001;
        tag_pool[1] = 28'h0000002;
        tag_pool[2] = 28'hFFFFFFF;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_flush(1'($urandom));
            end else begin
                logic [31:0] a;
                a = {tag_pool[$urandom_range(0, 2)], 2'($urandom), 2'($urandom)};
                access(1'($urandom_range(0, 2) == 0), a, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), saw, rd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
